cycle_monitor: RTL and testbench

- Parametrised successor to the top-level cycle counter, for simulation-run control and bus-activity accounting.
- Counts run cycles while enabled and monitors NUM_CH memory ports, each with a valid and write qualifier.
- Keeps saturating per-channel read and write counters.
- Ends the run on a CPU halt or when the cycle budget is exhausted, and emits a single done pulse that the bench uses to call $finish.
- Sits beside the cpu/memory pair and taps their bus strobes; it never drives the buses.

---
 rtl/cycle_monitor.sv | 121 ++++++++++++
 tb/tb_cycle_monitor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cycle_monitor.sv
// Run-control cycle counter with per-channel read/write activity counters.
// A run starts from IDLE on enable and ends on CPU halt or cycle-budget exhaustion.

module cycle_monitor_chan #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 count_en,
    input  logic                 valid,
    input  logic                 write,
    output logic [CNT_WIDTH-1:0] rd_cnt,
    output logic [CNT_WIDTH-1:0] wr_cnt
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (clear) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (count_en && valid) begin
            if (write) begin
                if (wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + 1'b1;
            end else begin
                if (rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end
endmodule

module cycle_monitor #(
    parameter int CNT_WIDTH  = 16,
    parameter int MAX_CYCLES = 2000,
    parameter int NUM_CH     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        clear,
    input  logic                        halt_in,
    input  logic [NUM_CH-1:0]           ch_valid,
    input  logic [NUM_CH-1:0]           ch_write,
    output logic [CNT_WIDTH-1:0]        cycle,
    output logic [NUM_CH*CNT_WIDTH-1:0] rd_cnt,
    output logic [NUM_CH*CNT_WIDTH-1:0] wr_cnt,
    output logic                        running,
    output logic                        halted,
    output logic                        timeout,
    output logic                        done
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CYCLE = CNT_WIDTH'(MAX_CYCLES - 1);

    state_t state_q, state_d;
    logic   run_act;
    logic   at_budget;

    assign run_act   = (state_q == RUN) && !clear;
    assign at_budget = (cycle == LAST_CYCLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // clear outranks halt, and halt outranks the budget.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (enable) state_d = RUN;
                RUN: begin
                    if (halt_in)        state_d = HALTED;
                    else if (at_budget) state_d = TIMEOUT;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle <= '0;
            done  <= 1'b0;
        end else begin
            done <= run_act && (halt_in || at_budget);
            if (clear)        cycle <= '0;
            else if (run_act) cycle <= cycle + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cycle_monitor_chan #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .count_en (run_act),
            .valid    (ch_valid[i]),
            .write    (ch_write[i]),
            .rd_cnt   (rd_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
            .wr_cnt   (wr_cnt[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    assign running = (state_q == RUN);
    assign halted  = (state_q == HALTED);
    assign timeout = (state_q == TIMEOUT);
endmodule

// File: tb/tb_cycle_monitor.sv
// Directed bench: three monitor instances (default, short budget, 4-bit counters).
module tb_cycle_monitor;
    logic       clk, rst_n, halt_in;
    logic [1:0] ch_valid, ch_write;
    logic       en0, clr0, en_t, clr_t, en_s, clr_s;

    logic [15:0] cyc0, cyc_t;
    logic [3:0]  cyc_s;
    logic [31:0] rd0, wr0, rd_t, wr_t;
    logic [7:0]  rd_s, wr_s;
    logic run0, hlt0, to0, dn0;
    logic run_t, hlt_t, to_t, dn_t;
    logic run_s, hlt_s, to_s, dn_s;

    int n_cmp = 0, n_err = 0;
    int dc0 = 0, dc_t = 0, dc_s = 0;

    cycle_monitor #(.CNT_WIDTH(16), .MAX_CYCLES(2000), .NUM_CH(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en0), .clear(clr0), .halt_in(halt_in),
        .ch_valid(ch_valid), .ch_write(ch_write), .cycle(cyc0), .rd_cnt(rd0), .wr_cnt(wr0),
        .running(run0), .halted(hlt0), .timeout(to0), .done(dn0));

    cycle_monitor #(.CNT_WIDTH(16), .MAX_CYCLES(16), .NUM_CH(2)) dut_t (
        .clk(clk), .rst_n(rst_n), .enable(en_t), .clear(clr_t), .halt_in(halt_in),
        .ch_valid(ch_valid), .ch_write(ch_write), .cycle(cyc_t), .rd_cnt(rd_t), .wr_cnt(wr_t),
        .running(run_t), .halted(hlt_t), .timeout(to_t), .done(dn_t));

    cycle_monitor #(.CNT_WIDTH(4), .MAX_CYCLES(15), .NUM_CH(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .enable(en_s), .clear(clr_s), .halt_in(halt_in),
        .ch_valid(ch_valid), .ch_write(ch_write), .cycle(cyc_s), .rd_cnt(rd_s), .wr_cnt(wr_s),
        .running(run_s), .halted(hlt_s), .timeout(to_s), .done(dn_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dn0 === 1'b1)  dc0++;
        if (dn_t === 1'b1) dc_t++;
        if (dn_s === 1'b1) dc_s++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; halt_in = 1'b0; ch_valid = 2'b00; ch_write = 2'b00;
        en0 = 0; clr0 = 0; en_t = 0; clr_t = 0; en_s = 0; clr_s = 0;
        step(2);
        chk("rst_cycle",   32'(cyc0), 0);
        chk("rst_running", 32'(run0), 0);
        chk("rst_flags",   32'({hlt0, to0, dn0}), 0);
        chk("rst_rd",      rd0, 0);
        chk("rst_wr",      wr0, 0);
        rst_n = 1'b1;
        step(2);
        chk("idle_hold", 32'({run0, cyc0}), 0);

        // Test 1: entry edge not counted, then 10 counted cycles.
        en0 = 1'b1;
        step(1);
        chk("t1_entry_run",   32'(run0), 1);
        chk("t1_entry_cycle", 32'(cyc0), 0);
        step(10);
        chk("t1_cycle",   32'(cyc0), 10);
        chk("t1_running", 32'(run0), 1);
        chk("t1_cnts",    rd0 | wr0, 0);
        chk("t1_nodone",  32'(dc0), 0);

        // Test 2: overlapping traffic, then halt at cycle 20.
        en0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ch_valid = 2'b11;
            ch_write = (k < 5) ? 2'b00 : 2'b01;
            step(1);
        end
        ch_valid = 2'b00; ch_write = 2'b00;
        step(2);
        chk("t2_pre_halt_cycle", 32'(cyc0), 20);
        halt_in = 1'b1;
        step(1);
        halt_in = 1'b0;
        chk("t2_cycle",  32'(cyc0), 21);
        chk("t2_halted", 32'(hlt0), 1);
        chk("t2_run",    32'(run0), 0);
        chk("t2_done",   32'(dn0), 1);
        chk("t2_rd0",    32'(rd0[15:0]), 5);
        chk("t2_wr0",    32'(wr0[15:0]), 3);
        chk("t2_rd1",    32'(rd0[31:16]), 8);
        chk("t2_wr1",    32'(wr0[31:16]), 0);
        step(1);
        chk("t2_done_fall", 32'(dn0), 0);
        ch_valid = 2'b11; ch_write = 2'b10; en0 = 1'b1;
        step(50);
        chk("t2_frz_cycle", 32'(cyc0), 21);
        chk("t2_frz_rd",    rd0, {16'd8, 16'd5});
        chk("t2_frz_wr",    wr0, {16'd0, 16'd3});
        chk("t2_frz_state", 32'({run0, hlt0, to0}), 3'b010);
        chk("t2_done_once", 32'(dc0), 1);
        ch_valid = 2'b00; ch_write = 2'b00;

        // Test 3: budget of 16 runs out.
        en_t = 1'b1;
        step(1);
        chk("t3_entry", 32'({run_t, cyc_t}), {1'b1, 16'd0});
        step(15);
        chk("t3_c15",     32'(cyc_t), 15);
        chk("t3_not_yet", 32'({run_t, to_t}), 2'b10);
        step(1);
        chk("t3_cycle",   32'(cyc_t), 16);
        chk("t3_timeout", 32'(to_t), 1);
        chk("t3_running", 32'(run_t), 0);
        chk("t3_done",    32'(dn_t), 1);
        ch_valid = 2'b11; ch_write = 2'b00;
        step(5);
        chk("t3_frz_rd",    rd_t, 0);
        chk("t3_frz_cycle", 32'(cyc_t), 16);
        chk("t3_done_once", 32'(dc_t), 1);
        ch_valid = 2'b00;

        // Test 6a: clear in TIMEOUT, with enable still high.
        clr_t = 1'b1;
        step(1);
        chk("t6_clr_state", 32'({run_t, hlt_t, to_t, dn_t}), 0);
        chk("t6_clr_cycle", 32'(cyc_t), 0);
        chk("t6_clr_done",  32'(dc_t), 1);
        clr_t = 1'b0;

        // Test 4: halt on the budget edge wins over timeout.
        step(1);
        chk("t4_entry", 32'({run_t, cyc_t}), {1'b1, 16'd0});
        step(15);
        chk("t4_c15", 32'(cyc_t), 15);
        halt_in = 1'b1;
        step(1);
        halt_in = 1'b0;
        chk("t4_halted",  32'(hlt_t), 1);
        chk("t4_timeout", 32'(to_t), 0);
        chk("t4_cycle",   32'(cyc_t), 16);
        chk("t4_done",    32'(dn_t), 1);
        step(3);
        chk("t4_done_once", 32'(dc_t), 2);
        chk("t4_still",     32'({hlt_t, to_t}), 2'b10);

        // Test 5: 4-bit counters stop at 15.
        ch_valid = 2'b11; ch_write = 2'b10;
        en_s = 1'b1;
        step(1);
        chk("t5_entry_rd", 32'(rd_s), 0);
        step(15);
        chk("t5_rd0",     32'(rd_s[3:0]), 15);
        chk("t5_wr1",     32'(wr_s[7:4]), 15);
        chk("t5_timeout", 32'(to_s), 1);
        step(5);
        chk("t5_sat_rd", 32'(rd_s[3:0]), 15);
        chk("t5_sat_cycle", 32'(cyc_s), 15);
        chk("t5_done_once", 32'(dc_s), 1);

        // Test 6b: clear coinciding with halt in RUN.
        clr_s = 1'b1;
        step(1);
        clr_s = 1'b0;
        step(1);
        chk("t6_rerun", 32'({run_s, cyc_s}), {1'b1, 4'd0});
        step(3);
        chk("t6_rd3", 32'(rd_s[3:0]), 3);
        halt_in = 1'b1; clr_s = 1'b1;
        step(1);
        halt_in = 1'b0; clr_s = 1'b0;
        chk("t6_ch_state", 32'({run_s, hlt_s, to_s, dn_s}), 0);
        chk("t6_ch_cnts",  32'({cyc_s, rd_s, wr_s}), 0);
        step(1);
        chk("t6_ch_nodone", 32'(dc_s), 1);
        step(2);
        chk("t6_mid_cycle", 32'(cyc_s), 2);

        // Test 6c: asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ar_s",    32'({run_s, cyc_s, rd_s, wr_s}), 0);
        chk("t6_ar_0",    32'({hlt0, cyc0}), 0);
        chk("t6_ar_rd0",  rd0, 0);
        chk("t6_ar_t",    32'({hlt_t, cyc_t}), 0);
        rst_n = 1'b1;
        ch_valid = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
